// File: rtl/vga_frame_monitor_if.sv
// vga_frame_monitor_if
// Groups the display-path signals seen by the VGA frame monitor: the sampled
// sync/RGB inputs with their pixel enable, and the qualified pixel stream
// plus status outputs.
//   master : the display path / bench side (drives I_*, observes O_*)
//   slave  : the monitor (observes I_*, drives O_*)
interface vga_frame_monitor_if;
    logic        I_pix_en;
    logic        I_hs;
    logic        I_vs;
    logic [3:0]  I_red;
    logic [3:0]  I_green;
    logic [3:0]  I_blue;
    logic [9:0]  O_x;
    logic [9:0]  O_y;
    logic [11:0] O_pix;
    logic        O_pix_valid;
    logic        O_sof;
    logic        O_locked;
    logic        O_err_hs;
    logic        O_err_vs;
    logic [15:0] O_frame_cnt;

    modport master (
        output I_pix_en, I_hs, I_vs, I_red, I_green, I_blue,
        input  O_x, O_y, O_pix, O_pix_valid, O_sof, O_locked,
               O_err_hs, O_err_vs, O_frame_cnt
    );

    modport slave (
        input  I_pix_en, I_hs, I_vs, I_red, I_green, I_blue,
        output O_x, O_y, O_pix, O_pix_valid, O_sof, O_locked,
               O_err_hs, O_err_vs, O_frame_cnt
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
// VGA sink: recovers pixel coordinates from hsync/vsync, checks line and frame
// timing, locks onto a clean stream and emits a qualified, registered pixel
// stream.
// Ports:
//   I_clk  : system clock
//   I_rst  : synchronous active-high reset
//   bus    : slave side of vga_frame_monitor_if
//            inputs  I_pix_en, I_hs, I_vs, I_red/I_green/I_blue
//            outputs O_x, O_y, O_pix, O_pix_valid, O_sof, O_locked,
//                    O_err_hs, O_err_vs, O_frame_cnt
module vga_frame_monitor #(
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_TOTAL     = 800,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_TOTAL     = 525,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input logic                I_clk,
    input logic                I_rst,
    vga_frame_monitor_if.slave bus
);

    localparam logic [1:0] ST_SEEK   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    localparam logic [9:0] HCNT_MAX    = 10'd1023;
    localparam logic [9:0] HCNT_PRESAT = 10'd1022;
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END       = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END       = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W    = 10'(H_SYNC);

    // prev registers hold "sync was asserted" flags, so reset value 0 = deasserted
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [1:0]  state_q, state_d;
    logic        skip_line_q, skip_line_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [11:0] pix_q, pix_d;
    logic        pix_valid_q, pix_valid_d, sof_q, sof_d, locked_q, locked_d;
    logic        err_hs_q, err_hs_d, err_vs_q, err_vs_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic       hs_act_s, vs_act_s, hs_rise_s, hs_fall_s, vs_rise_s;
    logic [9:0] hcnt_nxt_s, vcnt_nxt_s;
    logic       seeking_s, active_s, err_hs_s, err_vs_s, any_err_s;

    assign hs_act_s  = (bus.I_hs == SYNC_ACTIVE);
    assign vs_act_s  = (bus.I_vs == SYNC_ACTIVE);
    assign hs_rise_s = hs_act_s & ~hs_prev_q;
    assign hs_fall_s = ~hs_act_s & hs_prev_q;
    assign vs_rise_s = vs_act_s & ~vs_prev_q;

    // Counter values belonging to the current sample
    assign hcnt_nxt_s = hs_rise_s ? 10'd0 :
                        ((hcnt_q == HCNT_MAX) ? HCNT_MAX : (hcnt_q + 10'd1));
    assign vcnt_nxt_s = vs_rise_s ? 10'd0 :
                        (hs_rise_s ? (vcnt_q + 10'd1) : vcnt_q);

    assign seeking_s = (state_q == ST_SEEK);
    assign active_s  = (hcnt_nxt_s >= H_START) && (hcnt_nxt_s <= H_END) &&
                       (vcnt_nxt_s >= V_START) && (vcnt_nxt_s <= V_END);

    // Line checks are suppressed for a line that began before the VERIFY
    // entry edge (skip_line_q); the saturation check fires only on the step
    // into 1023, so a stuck hsync reports once.
    assign err_hs_s = ~seeking_s & (
                          (hs_rise_s & ~skip_line_q & (hcnt_q != H_LAST)) |
                          (hs_fall_s & ~skip_line_q & (hcnt_nxt_s != H_SYNC_W)) |
                          (~hs_rise_s & (hcnt_q == HCNT_PRESAT)));
    assign err_vs_s  = ~seeking_s & vs_rise_s & (vcnt_q != V_LAST);
    assign any_err_s = err_hs_s | err_vs_s;

    // Next-state logic: everything advances only on pixel-enabled samples
    always_comb begin
        hs_prev_d   = hs_prev_q;
        vs_prev_d   = vs_prev_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        state_d     = state_q;
        skip_line_d = skip_line_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_d       = pix_q;
        frame_cnt_d = frame_cnt_q;
        locked_d    = locked_q;
        pix_valid_d = 1'b0;
        sof_d       = 1'b0;
        err_hs_d    = 1'b0;
        err_vs_d    = 1'b0;
        if (bus.I_pix_en) begin
            hs_prev_d = hs_act_s;
            vs_prev_d = vs_act_s;
            hcnt_d    = hcnt_nxt_s;
            vcnt_d    = vcnt_nxt_s;
            err_hs_d  = err_hs_s;
            err_vs_d  = err_vs_s;

            if (seeking_s && vs_rise_s) begin
                skip_line_d = ~hs_rise_s;
            end else if (hs_rise_s) begin
                skip_line_d = 1'b0;
            end else begin
                skip_line_d = skip_line_q;
            end

            case (state_q)
                ST_SEEK: begin
                    if (vs_rise_s) begin
                        state_d = ST_VERIFY;
                    end else begin
                        state_d = ST_SEEK;
                    end
                end
                ST_VERIFY: begin
                    if (any_err_s) begin
                        state_d = ST_SEEK;
                    end else if (vs_rise_s) begin
                        state_d = ST_LOCK;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_LOCK: begin
                    if (any_err_s) begin
                        state_d = ST_SEEK;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
                default: state_d = ST_SEEK;
            endcase

            // A clean vs edge outside SEEK either confirms the lock or keeps it
            if (!seeking_s && vs_rise_s && !any_err_s) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                frame_cnt_d = frame_cnt_q;
            end

            locked_d = (state_d == ST_LOCK);

            if ((state_q == ST_LOCK) && active_s) begin
                pix_valid_d = 1'b1;
                x_d         = hcnt_nxt_s - H_START;
                y_d         = vcnt_nxt_s - V_START;
                pix_d       = {bus.I_red, bus.I_green, bus.I_blue};
                sof_d       = (hcnt_nxt_s == H_START) && (vcnt_nxt_s == V_START);
            end else begin
                pix_valid_d = 1'b0;
                sof_d       = 1'b0;
            end
        end else begin
            pix_valid_d = 1'b0;
            sof_d       = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            hcnt_q      <= 10'd0;
            vcnt_q      <= 10'd0;
            state_q     <= ST_SEEK;
            skip_line_q <= 1'b0;
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            pix_q       <= 12'd0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_hs_q    <= 1'b0;
            err_vs_q    <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            state_q     <= state_d;
            skip_line_q <= skip_line_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            sof_q       <= sof_d;
            locked_q    <= locked_d;
            err_hs_q    <= err_hs_d;
            err_vs_q    <= err_vs_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.O_x         = x_q;
    assign bus.O_y         = y_q;
    assign bus.O_pix       = pix_q;
    assign bus.O_pix_valid = pix_valid_q;
    assign bus.O_sof       = sof_q;
    assign bus.O_locked    = locked_q;
    assign bus.O_err_hs    = err_hs_q;
    assign bus.O_err_vs    = err_vs_q;
    assign bus.O_frame_cnt = frame_cnt_q;

endmodule
